// File: rtl/tx_fifo.sv
// Transmit-path byte FIFO between Int_Tx and the UART transmitter.
// The head byte is shown ahead of the pop, and the flags and occupancy are registered.
module tx_fifo #(
    parameter int B = 8,
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         WR_FIFO,
    input  logic [B-1:0] data_fifo,
    input  logic         RD_FIFO,
    output logic         fifo_full,
    output logic         fifo_empty,
    output logic [B-1:0] dout,
    output logic [W:0]   count,
    output logic         overflow,
    output logic         underflow
);

    localparam int         DEPTH      = 2 ** W;
    localparam logic [W:0] FULL_COUNT = (W + 1)'(DEPTH);
    localparam logic [W:0] ONE_COUNT  = (W + 1)'(1);
    localparam logic [W-1:0] ONE_PTR  = W'(1);

    logic [B-1:0] mem_q [DEPTH];

    logic [W-1:0] wr_ptr_q, wr_ptr_d;
    logic [W-1:0] rd_ptr_q, rd_ptr_d;
    logic [W:0]   count_q, count_d;
    logic         full_q, full_d;
    logic         empty_q, empty_d;
    logic         overflow_q, overflow_d;
    logic         underflow_q, underflow_d;
    logic         wr_en_s;
    logic         rd_en_s;

    // Accept decisions and all next-state values.
    always_comb begin
        // A full FIFO still accepts a write when a pop frees the slot in the same cycle.
        // An empty FIFO ignores the pop, so a byte never falls through in the cycle it is written.
        wr_en_s     = WR_FIFO & (~full_q | RD_FIFO);
        rd_en_s     = RD_FIFO & ~empty_q;
        overflow_d  = WR_FIFO & full_q & ~RD_FIFO;
        underflow_d = RD_FIFO & empty_q;

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + ONE_PTR;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_en_s) begin
            rd_ptr_d = rd_ptr_q + ONE_PTR;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + ONE_COUNT;
            2'b01:   count_d = count_q - ONE_COUNT;
            default: count_d = count_q;
        endcase

        full_d  = (count_d == FULL_COUNT);
        empty_d = (count_d == {(W + 1){1'b0}});
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wr_ptr_q    <= {W{1'b0}};
            rd_ptr_q    <= {W{1'b0}};
            count_q     <= {(W + 1){1'b0}};
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; its contents need no reset because the pointers define what is valid.
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= data_fifo;
        end
    end

    assign dout       = mem_q[rd_ptr_q];
    assign count      = count_q;
    assign fifo_full  = full_q;
    assign fifo_empty = empty_q;
    assign overflow   = overflow_q;
    assign underflow  = underflow_q;

endmodule

// File: doc/tx_fifo.md
Name: tx_fifo

Overview:
Transmit-path buffer directly downstream of the result-to-transmit interface (Int_Tx). It accepts bytes on WR_FIFO/data_fifo and returns fifo_full as back-pressure. It holds them in a circular buffer and presents them show-ahead to the UART transmitter, which pops them with RD_FIFO. It decouples single-cycle result bursts from the slow serial line.

Parameters:
B, 8, data width in bits
W, 4, address width; depth = 2**W entries (16 by default)

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous reset, active-low; all state cleared while low
WR_FIFO  input  1  write strobe from Int_Tx; one byte per cycle high
data_fifo  input  B  write data from Int_Tx
RD_FIFO  input  1  pop strobe from UART transmitter
fifo_full  output  1  buffer holds 2**W entries
fifo_empty  output  1  buffer holds 0 entries
dout  output  B  head-of-queue byte; valid while fifo_empty=0
count  output  W+1  current occupancy, 0..2**W
overflow  output  1  one-cycle pulse: write attempted while full and not accepted
underflow  output  1  one-cycle pulse: read attempted while empty

Behaviour:
- Reset (RESET=0, async):
  - wr_ptr=0, rd_ptr=0, count=0.
  - fifo_empty=1, fifo_full=0, overflow=0, underflow=0.
  - Memory contents are don't-care; dout is don't-care while empty.
- Storage: 2**W x B register array. wr_ptr and rd_ptr are W bits and wrap naturally from 2**W-1 to 0.
- Flags and count are registered and change only on the CLK edge after the event. fifo_full and fifo_empty are derived from the next-state count, so they update in the same edge as the pointers.
- dout = mem[rd_ptr], combinational from registered state (show-ahead).
  - The byte at the head is visible before RD_FIFO.
  - RD_FIFO consumes it; the next byte appears the cycle after the edge.
- Write only (WR_FIFO=1, RD_FIFO=0):
  - if not full: mem[wr_ptr]<=data_fifo, wr_ptr+1, count+1.
  - if full: nothing stored, pointers unchanged, overflow=1 next cycle.
- Read only (RD_FIFO=1, WR_FIFO=0):
  - if not empty: rd_ptr+1, count-1.
  - if empty: no change, underflow=1 next cycle.
- Simultaneous WR_FIFO=1 and RD_FIFO=1:
  - neither full nor empty: write and read both performed; count unchanged.
  - full: both performed (the read frees the slot the write fills); fifo_full stays 1; no overflow.
  - empty: write performed, read ignored (no same-cycle fall-through); count becomes 1; fifo_empty drops next cycle; underflow=1.
- Latency: a byte written at edge N is on dout with fifo_empty=0 after edge N (visible in cycle N+1) when the FIFO was empty.
- overflow and underflow are high for exactly one cycle per offending strobe, not sticky.
- Reset asserted mid-operation: pointers and count clear immediately; queued data is discarded; fifo_empty=1 without waiting for a clock edge.
- Ordering: strict FIFO order across pointer wrap-around.

Test Plan:
1. Reset low then high, no strobes -> fifo_empty=1, fifo_full=0, count=0, overflow=underflow=0.
2. Write 0xA5, then 0x3C on consecutive cycles -> after the first edge dout=0xA5 and fifo_empty=0; count=2. Pop once -> dout=0x3C, count=1. Pop again -> fifo_empty=1.
3. Write 16 bytes 0x00..0x0F -> fifo_full=1 and count=16 after the 16th edge. A 17th write of 0xFF -> overflow pulses for 1 cycle, count stays 16. Drain all 16 -> bytes read out 0x00..0x0F in order.
4. Full FIFO, WR_FIFO=RD_FIFO=1 with 0x77 -> 0x00 popped, 0x77 accepted, fifo_full stays 1, no overflow. Later drain shows 0x77 last.
5. Empty FIFO, WR_FIFO=RD_FIFO=1 with 0x5A -> count=1, dout=0x5A, underflow pulses once. Separately, RD_FIFO alone on empty -> underflow pulse, count stays 0.
6. Write 10 bytes, pop 8, write 12 more (pointer wrap), then pull RESET low mid-burst -> fifo_empty=1 and count=0 asynchronously. After release, a write of 0x11 reads back 0x11.
